gnn_0_example_load: RTL and testbench

GNN_0_EXAMPLE_LOAD -- requirements
Module: gnn_0_example_load

---
 rtl/gnn_0_example_load.sv | 208 ++++++++++++++++++++
 tb/tb_gnn_0_example_load.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_0_example_load.sv
// rtl/gnn_0_example_load.sv - load engine: instruction decode, DRAM read issue, beat-to-buffer write
//
// Purpose: decodes one load instruction, asks the read master for a DRAM
// transfer, and writes the first N returned beats to consecutive lines of the
// selected on-chip buffer (1_A, 2_A, 1_B or 2_B).
//
// Ports:
//   aclk, areset_n              clock, asynchronous active-low reset
//   ap_start / ap_done          start pulse in, completion pulse out
//   ctrl_addr_offset            DRAM base address added to the instruction offset
//   ctrl_instruction            load instruction
//   rd_ctrl_*                   read-master command (start pulse, address, size) and done pulse
//   s_axis_*                    read-master data stream
//   load_write_buffer_X_*       per-buffer write ports; only the selected one is ever non-zero
module gnn_0_example_load #(
  parameter int LOAD_INST_LENGTH   = 128,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int BUF_ADDR_WIDTH     = 11
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          rd_ctrl_start,
  input  logic                          rd_ctrl_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  rd_ctrl_xfer_size_in_bytes,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                          load_write_buffer_1_A_wen,
  output logic [BUF_ADDR_WIDTH-1:0]     load_write_buffer_1_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_A_data,
  output logic                          load_write_buffer_2_A_wen,
  output logic [BUF_ADDR_WIDTH-1:0]     load_write_buffer_2_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_A_data,
  output logic                          load_write_buffer_1_B_wen,
  output logic [BUF_ADDR_WIDTH-1:0]     load_write_buffer_1_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_B_data,
  output logic                          load_write_buffer_2_B_wen,
  output logic [BUF_ADDR_WIDTH-1:0]     load_write_buffer_2_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_B_data
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STREAM, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_1A, G_2A, G_1B, G_2B} grp_t;

  state_t                        state_q, state_d;
  grp_t                          grp_q, grp_d, grp_dec;
  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, dram_off;
  logic [C_XFER_SIZE_WIDTH-1:0]  rd_size_q, rd_size_d, xfer_sz;
  logic [15:0]                   n_q, n_d, cnt_q, cnt_d;
  logic [BUF_ADDR_WIDTH-1:0]     base_q, base_d;
  logic                          done_flag_q, done_flag_d;
  logic                          rd_start_q, rd_start_d;
  logic                          ap_done_q, ap_done_d;
  logic                          tready_q, tready_d;
  logic                          wr_en_q, wr_en_d;
  logic [BUF_ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                          beat_acc;

  assign beat_acc = s_axis_tvalid & tready_q;

  // Instruction field extraction; anything that is not exactly one of the
  // four one-hot codes falls back to buffer 1_A.
  always_comb begin
    dram_off       = '0;
    dram_off[31:0] = ctrl_instruction[127:96];
    xfer_sz        = '0;
    xfer_sz[15:0]  = ctrl_instruction[95:80];
    case (ctrl_instruction[5:0])
      6'b000010: grp_dec = G_2A;
      6'b000100: grp_dec = G_1B;
      6'b001000: grp_dec = G_2B;
      default:   grp_dec = G_1A;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    rd_addr_d   = rd_addr_q;
    rd_size_d   = rd_size_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    done_flag_d = done_flag_q;
    rd_start_d  = 1'b0;
    ap_done_d   = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    // The read master may finish before, during or after the stream, so its
    // done pulse is remembered from ISSUE until the load completes.
    if (state_q == S_ISSUE || state_q == S_STREAM || state_q == S_WAIT) begin
      done_flag_d = done_flag_q | rd_ctrl_done;
    end

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          grp_d       = grp_dec;
          rd_addr_d   = dram_off + ctrl_addr_offset;
          rd_size_d   = xfer_sz;
          n_d         = ctrl_instruction[63:48];
          base_d      = ctrl_instruction[32 +: BUF_ADDR_WIDTH];
          cnt_d       = '0;
          done_flag_d = 1'b0;
          wr_addr_d   = '0;
          wr_data_d   = '0;
          rd_start_d  = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = (n_q == 16'd0) ? S_WAIT : S_STREAM;
      end
      S_STREAM: begin
        if (beat_acc) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + cnt_q[BUF_ADDR_WIDTH-1:0];
          wr_data_d = s_axis_tdata;
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == n_q - 16'd1) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The last write left the pipeline register on the cycle WAIT was
        // entered, so only the done flag gates completion here.
        if (done_flag_q) begin
          ap_done_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        done_flag_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tready_d = (state_d == S_STREAM) || (state_d == S_WAIT);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= S_IDLE;
      grp_q       <= G_1A;
      rd_addr_q   <= '0;
      rd_size_q   <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      done_flag_q <= 1'b0;
      rd_start_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      tready_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      rd_addr_q   <= rd_addr_d;
      rd_size_q   <= rd_size_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      done_flag_q <= done_flag_d;
      rd_start_q  <= rd_start_d;
      ap_done_q   <= ap_done_d;
      tready_q    <= tready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign ap_done                    = ap_done_q;
  assign rd_ctrl_start              = rd_start_q;
  assign rd_ctrl_addr_offset        = rd_addr_q;
  assign rd_ctrl_xfer_size_in_bytes = rd_size_q;
  assign s_axis_tready              = tready_q;

  // One shared write register steered to the selected buffer; the other
  // three ports are forced to zero.
  assign load_write_buffer_1_A_wen  = wr_en_q & (grp_q == G_1A);
  assign load_write_buffer_1_A_addr = (grp_q == G_1A) ? wr_addr_q : '0;
  assign load_write_buffer_1_A_data = (grp_q == G_1A) ? wr_data_q : '0;
  assign load_write_buffer_2_A_wen  = wr_en_q & (grp_q == G_2A);
  assign load_write_buffer_2_A_addr = (grp_q == G_2A) ? wr_addr_q : '0;
  assign load_write_buffer_2_A_data = (grp_q == G_2A) ? wr_data_q : '0;
  assign load_write_buffer_1_B_wen  = wr_en_q & (grp_q == G_1B);
  assign load_write_buffer_1_B_addr = (grp_q == G_1B) ? wr_addr_q : '0;
  assign load_write_buffer_1_B_data = (grp_q == G_1B) ? wr_data_q : '0;
  assign load_write_buffer_2_B_wen  = wr_en_q & (grp_q == G_2B);
  assign load_write_buffer_2_B_addr = (grp_q == G_2B) ? wr_addr_q : '0;
  assign load_write_buffer_2_B_data = (grp_q == G_2B) ? wr_data_q : '0;

endmodule

// File: tb/tb_gnn_0_example_load.sv
// tb/tb_gnn_0_example_load.sv - scoreboard bench for gnn_0_example_load
module tb_gnn_0_example_load;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int BW = 11;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [127:0]  ctrl_instruction = '0;
  logic          rd_ctrl_start;
  logic          rd_ctrl_done = 1'b0;
  logic [AW-1:0] rd_ctrl_addr_offset;
  logic [31:0]   rd_ctrl_xfer_size_in_bytes;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          wen_1a, wen_2a, wen_1b, wen_2b;
  logic [BW-1:0] addr_1a, addr_2a, addr_1b, addr_2b;
  logic [DW-1:0] data_1a, data_2a, data_1b, data_2b;

  logic          wen_a  [4];
  logic [BW-1:0] addr_a [4];
  logic [DW-1:0] data_a [4];
  assign wen_a[0] = wen_1a;  assign addr_a[0] = addr_1a;  assign data_a[0] = data_1a;
  assign wen_a[1] = wen_2a;  assign addr_a[1] = addr_2a;  assign data_a[1] = data_2a;
  assign wen_a[2] = wen_1b;  assign addr_a[2] = addr_1b;  assign data_a[2] = data_1b;
  assign wen_a[3] = wen_2b;  assign addr_a[3] = addr_2b;  assign data_a[3] = data_2b;

  gnn_0_example_load dut (
    .aclk(aclk), .areset_n(areset_n), .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .rd_ctrl_start(rd_ctrl_start), .rd_ctrl_done(rd_ctrl_done),
    .rd_ctrl_addr_offset(rd_ctrl_addr_offset),
    .rd_ctrl_xfer_size_in_bytes(rd_ctrl_xfer_size_in_bytes),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .load_write_buffer_1_A_wen(wen_1a), .load_write_buffer_1_A_addr(addr_1a), .load_write_buffer_1_A_data(data_1a),
    .load_write_buffer_2_A_wen(wen_2a), .load_write_buffer_2_A_addr(addr_2a), .load_write_buffer_2_A_data(data_2a),
    .load_write_buffer_1_B_wen(wen_1b), .load_write_buffer_1_B_addr(addr_1b), .load_write_buffer_1_B_data(data_1b),
    .load_write_buffer_2_B_wen(wen_2b), .load_write_buffer_2_B_addr(addr_2b), .load_write_buffer_2_B_data(data_2b)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int            port;
    int            addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cur_port = 0, cur_start = 0, cur_n = 0, accepted = 0;
  int   start_cnt = 0, done_cnt = 0, exp_starts = 0;
  logic prev_start = 1'b0, prev_done = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic int grp_port(input logic [5:0] g);
    case (g)
      6'b000001: return 0;
      6'b000010: return 1;
      6'b000100: return 2;
      6'b001000: return 3;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: the k-th accepted beat of a load with k < N lands at
  // (start + k) mod 2048 on the decoded buffer, one clock after the handshake.
  task automatic model_accept(input logic [DW-1:0] d);
    exp_t e;
    if (accepted < cur_n) begin
      e.port = cur_port;
      e.addr = (cur_start + accepted) % 2048;
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    accepted++;
  endtask

  // Monitor / scoreboard
  always @(negedge aclk) begin
    int   nw, p, bad;
    exp_t e;
    nw = 0; p = 0; bad = 0;
    for (int i = 0; i < 4; i++) if (wen_a[i] === 1'b1) begin nw++; p = i; end
    if (nw > 1) begin
      chk("single_wen", 32'(nw), 32'd1);
    end else if (nw == 1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {1'b1, addr_a[p]}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_port", 32'(p), 32'(e.port));
        chk("wr_addr", 32'(addr_a[p]), 32'(e.addr));
        chk("wr_data", data_a[p], e.data);
        chk("wr_latency", 32'(cyc), 32'(e.cyc));
        for (int i = 0; i < 4; i++)
          if (i != p && (wen_a[i] !== 1'b0 || addr_a[i] !== '0 || data_a[i] !== '0)) bad++;
        chk("unselected_zero", 32'(bad), 32'd0);
      end
    end
    if (rd_ctrl_start === 1'b1) begin
      start_cnt++;
      if (prev_start) chk("rd_start_width", 1'b1, 1'b0);
    end
    if (ap_done === 1'b1) begin
      done_cnt++;
      chk("writes_done_before_ap_done", 32'(exp_q.size()), 32'd0);
      if (prev_done) chk("ap_done_width", 1'b1, 1'b0);
    end
    prev_start = (rd_ctrl_start === 1'b1);
    prev_done  = (ap_done === 1'b1);
  end

  task automatic start_load(input logic [5:0] grp, input int st, input int n,
                            input logic [31:0] off, input logic [15:0] sz, input logic [AW-1:0] base);
    logic [127:0]  inst;
    logic [AW-1:0] ea;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[127:96] = off;
    inst[95:80]  = sz;
    inst[63:48]  = 16'(n);
    inst[42:32]  = 11'(st);
    inst[5:0]    = grp;
    cur_port = grp_port(grp); cur_start = st; cur_n = n; accepted = 0;
    ctrl_instruction = inst;
    ctrl_addr_offset = base;
    ap_start = 1'b1;
    @(negedge aclk);
    ap_start = 1'b0;
    exp_starts++;
    ea = base + {32'd0, off};
    chk("rd_ctrl_start_pulse", rd_ctrl_start, 1'b1);
    chk("rd_addr", rd_ctrl_addr_offset, ea);
    chk("rd_size", rd_ctrl_xfer_size_in_bytes, {16'd0, sz});
    ctrl_instruction = {$urandom, $urandom, $urandom, $urandom};
    ctrl_addr_offset = {$urandom, $urandom};
  endtask

  // mode 0: back-to-back, 1: toggle every cycle, 2: random valid
  task automatic send_beats(input int nb, input int mode, input int budget, output int got);
    logic [DW-1:0] d;
    int  c;
    bit  tv;
    got = 0; c = 0; tv = 1'b0; d = '0;
    while (got < nb && c < budget) begin
      case (mode)
        0:       tv = 1'b1;
        1:       tv = ~tv;
        default: tv = 1'($urandom_range(0, 1));
      endcase
      s_axis_tvalid = tv;
      if (tv) begin d = rand_beat(); s_axis_tdata = d; end
      if (tv && s_axis_tready === 1'b1) begin model_accept(d); got++; end
      @(negedge aclk);
      c++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic pulse_done();
    rd_ctrl_done = 1'b1;
    @(negedge aclk);
    rd_ctrl_done = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int c;
    c = 0;
    while (done_cnt == prev && c < budget) begin
      @(posedge aclk); #1;
      c++;
    end
    chk("ap_done_seen", 32'(done_cnt), 32'(prev + 1));
    chk("rd_start_count", 32'(start_cnt), 32'(exp_starts));
    @(negedge aclk);
    @(negedge aclk);
    chk("ap_done_single", 32'(done_cnt), 32'(prev + 1));
  endtask

  initial begin
    int got, prev, n, st, mode;
    logic [5:0]    grp;
    logic [AW-1:0] held;

    repeat (3) @(negedge aclk);
    chk("rst_ap_done", ap_done, 1'b0);
    chk("rst_rd_start", rd_ctrl_start, 1'b0);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_wen", {wen_1a, wen_2a, wen_1b, wen_2b}, 4'b0);
    chk("rst_addrs", {addr_1a, addr_2a, addr_1b, addr_2b}, '0);
    chk("rst_data_or", data_1a | data_2a | data_1b | data_2b, '0);
    chk("rst_rd_addr", rd_ctrl_addr_offset, '0);
    chk("rst_rd_size", rd_ctrl_xfer_size_in_bytes, '0);
    areset_n = 1'b1;
    @(negedge aclk);

    // basic: 1_B, start 0x010, N=4, back-to-back, done after the last beat
    prev = done_cnt;
    start_load(6'b000100, 'h010, 4, 32'h1000_0040, 16'h0100, 64'h0000_0001_0000_0000);
    send_beats(4, 0, 40, got);
    chk("basic_beats", 32'(got), 32'd4);
    pulse_done();
    wait_done(prev, 30);

    // back-pressure and buffer address wrap
    prev = done_cnt;
    start_load(6'b000001, 'h7FE, 4, 32'hFFFF_FFF0, 16'h0100, 64'hFFFF_FFFF_FFFF_FF00);
    send_beats(4, 1, 60, got);
    chk("wrap_beats", 32'(got), 32'd4);
    pulse_done();
    wait_done(prev, 30);

    // early rd_ctrl_done during ISSUE, 6 beats offered for N=4
    prev = done_cnt;
    start_load(6'b000010, 'h123, 4, 32'h0000_2000, 16'h0100, 64'h0);
    pulse_done();
    send_beats(6, 0, 20, got);
    wait_done(prev, 30);

    // N=0, invalid group, second ap_start while busy
    prev = done_cnt;
    start_load(6'b110000, 'h055, 0, 32'h0000_3000, 16'h0000, 64'h10);
    held = rd_ctrl_addr_offset;
    send_beats(2, 0, 10, got);
    ctrl_instruction = {32'hDEAD_0000, 16'h0040, 16'h0, 16'd5, 16'h0200, 26'h0, 6'b000100};
    ap_start = 1'b1;
    @(negedge aclk);
    ap_start = 1'b0;
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1;
    chk("busy_start_ignored", 32'(start_cnt), 32'(exp_starts));
    chk("busy_addr_held", rd_ctrl_addr_offset, held);
    chk("no_done_before_rd_done", 32'(done_cnt), 32'(prev));
    @(negedge aclk);
    pulse_done();
    wait_done(prev, 30);

    // reset in the middle of an N=8 load
    start_load(6'b001000, 'h100, 8, 32'h0000_4000, 16'h0200, 64'h0);
    send_beats(2, 0, 40, got);
    chk("pre_reset_wen", wen_2b, 1'b1);
    #1 areset_n = 1'b0;
    #1;
    chk("async_rst_wen", {wen_1a, wen_2a, wen_1b, wen_2b}, 4'b0);
    chk("async_rst_tready", s_axis_tready, 1'b0);
    chk("async_rst_rd_addr", rd_ctrl_addr_offset, '0);
    exp_q.delete();
    accepted = cur_n;
    s_axis_tvalid = 1'b1;
    repeat (3) @(negedge aclk);
    s_axis_tvalid = 1'b0;
    areset_n = 1'b1;
    @(negedge aclk);
    prev = done_cnt;
    start_load(6'b000001, 'h3F0, 3, 32'h0000_5000, 16'h00C0, 64'h0);
    send_beats(3, 2, 60, got);
    chk("post_reset_beats", 32'(got), 32'd3);
    pulse_done();
    wait_done(prev, 30);

    // randomized loads
    for (int it = 0; it < 6; it++) begin
      mode = $urandom_range(0, 4);
      grp  = (mode < 4) ? (6'b1 << mode) : 6'($urandom);
      st   = $urandom_range(0, 2047);
      n    = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      prev = done_cnt;
      start_load(grp, st, n, $urandom, 16'($urandom), {$urandom, $urandom});
      if (it[0]) pulse_done();
      send_beats(n, mode, 8 * n + 20, got);
      chk("rand_beats", 32'(got), 32'(n));
      if (!it[0]) pulse_done();
      wait_done(prev, 30);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
